// File: rtl/bcd_arb_pkg.sv
// rtl/bcd_arb_pkg.sv - shared constants, tag type and range helper for bcd_cvt_arbiter
package bcd_arb_pkg;

    localparam int DATA_W   = 17;
    localparam int DEC_W    = 20;
    localparam int ID_MAX_W = 3;

    localparam logic [DATA_W-1:0] MAG_MAX     = 17'd32767;
    localparam logic [DATA_W-1:0] MAG_NEG_MAX = 17'h18001;
    localparam logic [DEC_W-1:0]  MAG_MAX_BCD = 20'h32767;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
        logic                neg;
        logic                err;
    } tag_t;

    // Valid range is the symmetric [-32767, 32767]; -32768 has no positive twin.
    function automatic logic out_of_range(input logic [DATA_W-1:0] d);
        return (~d[16] & d[15]) | (d[16] & (~d[15] | (d[14:0] == 15'd0)));
    endfunction

endpackage

// File: rtl/bcd_cvt_arbiter_rr_arbiter.sv
// rtl/bcd_cvt_arbiter_rr_arbiter.sv - combinational round-robin arbiter, search starts after i_ptr
module rr_arbiter #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx
);

    logic w_found;
    int   w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 1; k <= N; k++) begin
            w_pos = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[W'(w_pos)]) begin
                w_found              = 1'b1;
                o_grant[W'(w_pos)]   = 1'b1;
                o_idx                = W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/bcd_cvt_arbiter.sv
// rtl/bcd_cvt_arbiter.sv - shares one 3-cycle binary-to-BCD converter among N_REQ requesters
// Optional saturation of out-of-range operands: define BCD_ARB_SAT_EN.
module bcd_cvt_arbiter
    import bcd_arb_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int CVT_LAT = 3,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [DATA_W*N_REQ-1:0]   req_data,
    output logic [DATA_W-1:0]         cvt_hex,
    input  logic [DEC_W-1:0]          cvt_dec,
    output logic                      resp_valid,
    output logic [ID_W-1:0]           resp_id,
    output logic [DEC_W-1:0]          resp_dec,
    output logic                      resp_neg,
    output logic                      resp_err,
    output logic                      busy
);

    logic [N_REQ-1:0]  w_grant;
    logic [ID_W-1:0]   w_idx;
    logic [ID_W-1:0]   r_ptr;
    logic              w_xfer;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] w_operand;
    logic              w_err;
    logic              w_neg;
    logic              w_busy;
    tag_t              r_tag [0:CVT_LAT];

    rr_arbiter #(.N(N_REQ)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign req_ready = w_grant;
    assign w_xfer    = |req_valid;

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) w_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign w_err = out_of_range(w_data);
    assign w_neg = w_data[DATA_W-1];

    always_comb begin
        w_operand = w_data;
`ifdef BCD_ARB_SAT_EN
        if (w_err) w_operand = w_neg ? MAG_NEG_MAX : MAG_MAX;
`else
        if (w_err) w_operand = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= ID_W'(N_REQ - 1);
            cvt_hex <= '0;
        end else if (w_xfer) begin
            r_ptr   <= w_idx;
            cvt_hex <= w_operand;
        end
    end

    // Tag stage CVT_LAT lines up with the cycle cvt_dec carries that operand's result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= CVT_LAT; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0].valid <= w_xfer;
            r_tag[0].id    <= ID_MAX_W'(w_idx);
            r_tag[0].neg   <= w_neg;
            r_tag[0].err   <= w_err;
            for (int i = 1; i <= CVT_LAT; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_dec   <= '0;
            resp_neg   <= 1'b0;
            resp_err   <= 1'b0;
        end else if (r_tag[CVT_LAT].valid) begin
            resp_valid <= 1'b1;
            resp_id    <= ID_W'(r_tag[CVT_LAT].id);
            resp_neg   <= r_tag[CVT_LAT].neg;
            resp_err   <= r_tag[CVT_LAT].err;
`ifdef BCD_ARB_SAT_EN
            resp_dec   <= r_tag[CVT_LAT].err ? MAG_MAX_BCD : cvt_dec;
`else
            resp_dec   <= r_tag[CVT_LAT].err ? '0 : cvt_dec;
`endif
        end else begin
            resp_valid <= 1'b0;
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i <= CVT_LAT; i++) w_busy = w_busy | r_tag[i].valid;
    end

    assign busy = w_busy;

endmodule

// File: tb/tb_bcd_cvt_arbiter.sv
// tb/tb_bcd_cvt_arbiter.sv - directed vector bench for bcd_cvt_arbiter with a 3-stage converter model
module tb_bcd_cvt_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [17*N-1:0] req_data = '0;
    logic [16:0]   cvt_hex;
    logic [19:0]   cvt_dec;
    logic          resp_valid;
    logic [1:0]    resp_id;
    logic [19:0]   resp_dec;
    logic          resp_neg;
    logic          resp_err;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_cvt_arbiter #(.N_REQ(N), .CVT_LAT(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .cvt_hex    (cvt_hex),
        .cvt_dec    (cvt_dec),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_dec   (resp_dec),
        .resp_neg   (resp_neg),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] to_bcd(input logic [16:0] h);
        int v;
        logic [19:0] r;
        v = int'($signed(h));
        if (v < 0) v = -v;
        r = '0;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Converter model: unresettable 3-edge pipeline, as in the parent.
    logic [19:0] cv_p1, cv_p2;
    always @(posedge clk) begin
        cv_p1   <= to_bcd(cvt_hex);
        cv_p2   <= cv_p1;
        cvt_dec <= cv_p2;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          rq;
        logic [16:0] data;
        logic [19:0] dec;
        logic        neg;
        logic        err;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input int i, input vec_t v);
        int n;
        @(negedge clk);
        req_valid = '0;
        req_valid[v.rq] = 1'b1;
        req_data[17*v.rq +: 17] = v.data;
        #1;
        check($sformatf("v%0d ready", i), 32'(req_ready), 32'(4'(1) << v.rq));
        @(negedge clk);
        req_valid = '0;
        check($sformatf("v%0d busy", i), 32'(busy), 32'd1);
        n = 1;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("v%0d latency", i), 32'(n), 32'd5);
        check($sformatf("v%0d id", i), 32'(resp_id), 32'(v.rq));
        check($sformatf("v%0d dec", i), 32'(resp_dec), 32'(v.dec));
        check($sformatf("v%0d neg", i), 32'(resp_neg), 32'(v.neg));
        check($sformatf("v%0d err", i), 32'(resp_err), 32'(v.err));
        @(negedge clk);
        check($sformatf("v%0d pulse", i), 32'(resp_valid), 32'd0);
    endtask

    logic [16:0] s_data [4];
    logic [19:0] s_dec  [4];
    logic [16:0] c_data [6];
    logic [19:0] c_dec  [6];

    initial begin
        vecs[0] = '{2, 17'h1FB2E, 20'h01234, 1'b1, 1'b0};
        vecs[1] = '{0, 17'h07FFF, 20'h32767, 1'b0, 1'b0};
        vecs[2] = '{1, 17'h18001, 20'h32767, 1'b1, 1'b0};
        vecs[3] = '{3, 17'h00000, 20'h00000, 1'b0, 1'b0};
`ifdef BCD_ARB_SAT_EN
        vecs[4] = '{0, 17'h08000, 20'h32767, 1'b0, 1'b1};
        vecs[5] = '{1, 17'h18000, 20'h32767, 1'b1, 1'b1};
        vecs[8] = '{0, 17'h10000, 20'h32767, 1'b1, 1'b1};
`else
        vecs[4] = '{0, 17'h08000, 20'h00000, 1'b0, 1'b1};
        vecs[5] = '{1, 17'h18000, 20'h00000, 1'b1, 1'b1};
        vecs[8] = '{0, 17'h10000, 20'h00000, 1'b1, 1'b1};
`endif
        vecs[6] = '{2, 17'h00001, 20'h00001, 1'b0, 1'b0};
        vecs[7] = '{3, 17'h1FFFF, 20'h00001, 1'b1, 1'b0};

        s_data = '{17'h00005, 17'h1FFF6, 17'h00100, 17'h07000};
        s_dec  = '{20'h00005, 20'h00010, 20'h00256, 20'h28672};
        c_data = '{17'h00007, 17'h003EF, 17'h007D7, 17'h00BBF, 17'h00FA7, 17'h0138F};
        c_dec  = '{20'h00007, 20'h01007, 20'h02007, 20'h03007, 20'h04007, 20'h05007};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst ready", 32'(req_ready), 32'd0);
        check("rst cvt_hex", 32'(cvt_hex), 32'd0);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_dec", 32'(resp_dec), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset with three conversions in flight.
        @(negedge clk);
        req_valid = 4'b0010;
        req_data[17 +: 17] = 17'h00123;
        repeat (3) @(negedge clk);
        req_valid = '0;
        check("mid busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid rst ready", 32'(req_ready), 32'd0);
        check("mid rst cvt_hex", 32'(cvt_hex), 32'd0);
        check("mid rst outs", 32'({resp_valid, resp_id, resp_dec, resp_neg, resp_err}), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("post rst %0d resp_valid", k), 32'(resp_valid), 32'd0);
        end

        // All four requesters continuously valid for 8 cycles.
        for (int r = 0; r < 4; r++) req_data[17*r +: 17] = s_data[r];
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check($sformatf("rr %0d resp_valid", k), 32'(resp_valid), 32'(k >= 5 && k < 13));
            if (k >= 5 && k < 13) begin
                check($sformatf("rr %0d id", k), 32'(resp_id), 32'((k - 5) % 4));
                check($sformatf("rr %0d dec", k), 32'(resp_dec), 32'(s_dec[(k - 5) % 4]));
            end
            check($sformatf("rr %0d busy", k), 32'(busy), 32'(k >= 1 && k <= 11));
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            check($sformatf("rr %0d ready", k), 32'(req_ready), (k < 8) ? 32'(4'(1) << (k % 4)) : 32'd0);
        end

        // One requester streaming new data every accepted cycle.
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            check($sformatf("chg %0d resp_valid", k), 32'(resp_valid), 32'(k >= 5 && k <= 10));
            if (k >= 5 && k <= 10) begin
                check($sformatf("chg %0d id", k), 32'(resp_id), 32'd2);
                check($sformatf("chg %0d dec", k), 32'(resp_dec), 32'(c_dec[k - 5]));
                check($sformatf("chg %0d neg", k), 32'(resp_neg), 32'd0);
            end
            check($sformatf("chg %0d busy", k), 32'(busy), 32'(k >= 1 && k <= 9));
            if (k < 6) begin
                req_valid = 4'b0100;
                req_data[34 +: 17] = c_data[k];
            end else begin
                req_valid = '0;
            end
            #1;
            check($sformatf("chg %0d ready", k), 32'(req_ready), (k < 6) ? 32'd4 : 32'd0);
        end
        check("idle cvt_hex hold", 32'(cvt_hex), 32'h0138F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_cvt_arbiter.md
Name: bcd_cvt_arbiter

Overview:
- Shares one pipelined binary-to-BCD converter (17-bit two's-complement in, 20-bit unsigned BCD magnitude out, fixed 3-cycle latency, no valid/reset of its own) between N_REQ requesters.
- Round-robin valid/ready intake, one issue per cycle, range checking.
- Tracks in-flight conversions with a tag pipeline and returns the BCD result with requester ID and sign flag.
- Sits between display/arithmetic clients and the converter instance in the parent.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CVT_LAT, 3, converter latency in clock edges from cvt_hex change to cvt_dec valid.
- ID_W, $clog2(N_REQ), width of resp_id (derived, not overridden).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester ready; one-hot or zero.
- req_data  in  17*N_REQ  packed 17-bit two's-complement values; requester i at [17*i+16:17*i].
- cvt_hex  out  17  registered operand to the converter.
- cvt_dec  in  20  converter BCD magnitude output.
- resp_valid  out  1  one-cycle result pulse.
- resp_id  out  ID_W  requester index of the result.
- resp_dec  out  20  5-digit BCD magnitude.
- resp_neg  out  1  operand was negative.
- resp_err  out  1  operand outside [-32767, 32767].
- busy  out  1  any conversion accepted and not yet returned.

Behaviour:
- Reset values: req_ready=0, cvt_hex=0, resp_valid=0, resp_id=0, resp_dec=0, resp_neg=0, resp_err=0, busy=0; tag pipeline cleared; RR pointer = N_REQ-1, so requester 0 wins first.
- Arbitration:
  - Combinational round robin over req_valid, starting at pointer+1.
  - req_ready[g]=1 only for the winner g; all zero when no request.
  - Transfer occurs when req_valid[g] & req_ready[g]; the pointer updates to g on transfer.
  - No backpressure: every cycle with a request issues one conversion.
  - The requester must hold req_valid/req_data stable until ready.
- Range check on accepted data d:
  - In range: -32767 ≤ d ≤ 32767.
  - Out of range: d > 32767 (d[16]=0, d[15]=1), or d ≤ -32768.
  - Out of range sets tag err=1 and loads cvt_hex with 0.
  - In range loads cvt_hex with d unchanged; the converter strips the sign itself.
- Tag pipeline:
  - Depth CVT_LAT+1; entry = {valid, id, neg, err}.
  - Stage 0 loads at the handshake edge (same edge as cvt_hex).
  - Shifts every cycle, with bubbles where there is no transfer.
  - neg = d[16].
- Output:
  - At the edge where the last tag stage is valid, register resp_valid=1, resp_id, resp_neg, resp_err, and resp_dec = cvt_dec (or 0 when err).
  - Otherwise resp_valid=0; the other resp_* fields hold their last value.
- Latency: request accepted in cycle T gives resp_valid in cycle T+CVT_LAT+2 (T+5 at default). Throughput one per cycle; results return in acceptance order.
- busy = OR of all tag valid bits, plus resp_valid not included.
- cvt_hex holds its value on idle cycles.
- Reset mid-operation: all tags are discarded and no resp_valid follows reset release, even though the converter's internal registers keep stale data.

Optional Feature:
- Macro BCD_ARB_SAT_EN.
- Defined: out-of-range operands saturate.
  - cvt_hex is loaded with +32767 (17'h07FFF) or -32767 (17'h18001) by sign.
  - resp_dec = 20'h32767.
  - resp_neg = d[16].
  - resp_err = 1 (still flags the clamp).
- Undefined: zero-and-error behaviour as above.

Decomposition:
- Package bcd_arb_pkg holds:
  - constants DATA_W=17, DEC_W=20, MAG_MAX=17'd32767, MAG_MAX_BCD=20'h32767;
  - the tag struct type {valid, id, neg, err}.
- One sub-module: rr_arbiter (parameter N; inputs req vector and pointer; outputs one-hot grant and encoded index).
- Range check, cvt_hex register, tag shift register and output register stay in bcd_cvt_arbiter.

Test Plan:
- Single request, requester 2 sends 17'h1FB2E (-1234), others idle -> req_ready[2] in the same cycle; resp_valid 5 cycles later; resp_id=2, resp_dec=20'h01234, resp_neg=1, resp_err=0.
- All four requesters valid continuously with distinct values -> grants 0,1,2,3,0,1… one per cycle; resp_valid held high back-to-back; resp_id sequence matches the grant order.
- Boundaries:
  - 17'h07FFF -> 20'h32767, neg=0.
  - 17'h18001 -> 20'h32767, neg=1.
  - 17'h00000 -> 20'h00000, neg=0, err=0.
- Out-of-range 17'h08000 and 17'h18000:
  - SAT_EN off -> resp_dec=0, err=1.
  - SAT_EN on -> resp_dec=20'h32767, err=1, neg=0/1 respectively.
- Reset with 3 conversions in flight: rst_n low for 2 cycles mid-stream -> all outputs 0 immediately; no resp_valid in the 10 cycles after release; the next request behaves normally with requester 0 prioritised.
- Single requester holds valid with changing data each accepted cycle -> accepted every cycle; results in order, each exactly 5 cycles after acceptance; busy falls 1 cycle before the last resp_valid ends.
